// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default bus widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access-latency down-counter: loaded on grant, terminal count flags the last ACCESS cycle.
module mem_lat_counter #(
   parameter int MEM_LAT = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic lat_last
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign lat_last = dec && (cnt_q == '0);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between IF and MEM stages: data priority with a fetch
// anti-starvation guard, mem_* held from grant latches for the whole access.
//
//   state     | meaning
//   ST_IDLE   | arbitrate; grant latches owner/addr/we/wdata
//   ST_ACCESS | drive memory for MEM_LAT cycles, capture rdata on the last
//   ST_DONE   | owner's ready pulses for one cycle
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic              grant;
   logic              in_access;
   logic              lat_last;

   assign in_access = (state_q == ST_ACCESS);

   mem_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (grant),
      .dec      (in_access),
      .lat_last (lat_last)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ready_d = 1'b0;
      d_ready_d  = 1'b0;
      grant      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               grant   = 1'b1;
               state_d = ST_ACCESS;
               // Fetch only beats a pending data request once it has lost STARVE_MAX times in a row.
               if (if_req && (!d_req || (starve_q == STARVE_LIM))) begin
                  owner_d  = OWN_IF;
                  addr_d   = if_addr;
                  we_d     = 1'b0;
                  wdata_d  = '0;
                  starve_d = '0;
               end else begin
                  owner_d = OWN_D;
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
                  if (if_req && (starve_q < STARVE_LIM)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         ST_ACCESS: begin
            if (lat_last) begin
               state_d = ST_DONE;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  d_ready_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ready_q <= if_ready_d;
         d_ready_q  <= d_ready_d;
      end
   end

   assign mem_en    = in_access;
   assign mem_we    = in_access && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;
   assign stall_if  = if_req && !if_ready_q;
   assign stall_mem = d_req && !d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT 2 and 1) share one stimulus; a timeline model of each access
// predicts every output each cycle, and directed literals pin the spec's timing examples.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic clk;
   logic reset_n;
   logic if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;

   logic [31:0] if_rdata_2, d_rdata_2, mem_addr_2, mem_wdata_2, mem_rdata_2;
   logic        if_ready_2, d_ready_2, mem_en_2, mem_we_2, stall_if_2, stall_mem_2;
   logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
   logic        if_ready_1, d_ready_1, mem_en_1, mem_we_1, stall_if_1, stall_mem_1;

   int n_cmp;
   int n_fail;

   // Model of each arbiter: an access is a timeline numbered from the grant.
   int          lat    [2];
   bit          busy   [2];
   int          age    [2];
   bit          mown_d [2];
   bit          mwe    [2];
   int          starve [2];
   logic [31:0] maddr  [2];
   logic [31:0] mwdata [2];
   logic [31:0] e_if_rd[2];
   logic [31:0] e_d_rd [2];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C22_0004;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign mem_rdata_2 = memfn(mem_addr_2);
   assign mem_rdata_1 = memfn(mem_addr_1);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut2 (
      .clock(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_2), .if_ready(if_ready_2),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_2), .d_ready(d_ready_2),
      .mem_en(mem_en_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2), .mem_wdata(mem_wdata_2),
      .mem_rdata(mem_rdata_2), .stall_if(stall_if_2), .stall_mem(stall_mem_2)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
      .clock(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_1), .d_ready(d_ready_1),
      .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
      .mem_rdata(mem_rdata_1), .stall_if(stall_if_1), .stall_mem(stall_mem_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance the model across one rising edge, using the inputs present at that edge.
   task automatic model_step();
      bit fetch_wins;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            busy[i] = 0; age[i] = 0; starve[i] = 0; mown_d[i] = 0; mwe[i] = 0;
            maddr[i] = '0; mwdata[i] = '0; e_if_rd[i] = '0; e_d_rd[i] = '0;
         end else if (!busy[i]) begin
            if (if_req || d_req) begin
               fetch_wins = if_req && (!d_req || starve[i] == SMAX);
               if (fetch_wins) begin
                  mown_d[i] = 0; maddr[i] = if_addr; mwe[i] = 0; starve[i] = 0;
               end else begin
                  mown_d[i] = 1; maddr[i] = d_addr; mwe[i] = d_we; mwdata[i] = d_wdata;
                  if (if_req && starve[i] < SMAX) starve[i]++;
               end
               busy[i] = 1;
               age[i]  = 1;
            end
         end else if (age[i] <= lat[i]) begin
            if (age[i] == lat[i]) begin
               if (!mown_d[i]) e_if_rd[i] = memfn(maddr[i]);
               else if (!mwe[i]) e_d_rd[i] = memfn(maddr[i]);
            end
            age[i]++;
         end else begin
            busy[i] = 0;
         end
      end
   endtask

   task automatic check_inst(input int i, input logic en, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] ird, input logic irdy,
                             input logic [31:0] drd, input logic drdy,
                             input logic sif, input logic smem);
      bit e_en, e_irdy, e_drdy;
      string p;
      p      = (i == 0) ? "L2" : "L1";
      e_en   = busy[i] && age[i] <= lat[i];
      e_irdy = busy[i] && age[i] == lat[i] + 1 && !mown_d[i];
      e_drdy = busy[i] && age[i] == lat[i] + 1 && mown_d[i];
      chk1 ({p, " mem_en"},    en,   e_en);
      chk1 ({p, " mem_we"},    we,   e_en && mwe[i]);
      chk32({p, " mem_addr"},  addr, maddr[i]);
      if (e_en && mwe[i]) chk32({p, " mem_wdata"}, wd, mwdata[i]);
      chk32({p, " if_rdata"},  ird,  e_if_rd[i]);
      chk1 ({p, " if_ready"},  irdy, e_irdy);
      chk32({p, " d_rdata"},   drd,  e_d_rd[i]);
      chk1 ({p, " d_ready"},   drdy, e_drdy);
      chk1 ({p, " stall_if"},  sif,  if_req && !e_irdy);
      chk1 ({p, " stall_mem"}, smem, d_req && !e_drdy);
   endtask

   // Check the current cycle on the falling edge, then cross the next rising edge.
   task automatic tick();
      @(negedge clk);
      check_inst(0, mem_en_2, mem_we_2, mem_addr_2, mem_wdata_2, if_rdata_2, if_ready_2,
                 d_rdata_2, d_ready_2, stall_if_2, stall_mem_2);
      check_inst(1, mem_en_1, mem_we_1, mem_addr_1, mem_wdata_1, if_rdata_1, if_ready_1,
                 d_rdata_1, d_ready_1, stall_if_1, stall_mem_1);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      lat[0] = 2; lat[1] = 1;
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      @(posedge clk);
      model_step();
      #1;
      tick();
      reset_n = 1'b1;
      #1;
      chk1 ("rst if_ready", if_ready_2, 1'b0);
      chk1 ("rst d_ready", d_ready_2, 1'b0);
      chk1 ("rst mem_en", mem_en_2, 1'b0);
      chk32("rst mem_addr", mem_addr_2, 32'h0);
      chk32("rst if_rdata", if_rdata_2, 32'h0);

      // Fetch only
      if_req = 1'b1; if_addr = 32'h40;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk1("s1 stall_if", stall_if_2, c < 3);
         chk1("s1 mem_en", mem_en_2, c == 1 || c == 2);
         if (c == 1 || c == 2) chk32("s1 mem_addr", mem_addr_2, 32'h40);
         if (c == 2) begin
            chk1 ("s1 L1 if_ready", if_ready_1, 1'b1);
            chk32("s1 L1 if_rdata", if_rdata_1, 32'h8C22_0004);
         end
         if (c == 3) begin
            chk1 ("s1 if_ready", if_ready_2, 1'b1);
            chk32("s1 if_rdata", if_rdata_2, 32'h8C22_0004);
         end
         tick();
      end
      if_req = 1'b0;
      repeat (4) tick();
      do_reset();

      // Simultaneous requests: data first, fetch next
      if_req = 1'b1; if_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk1("s2 stall_if", stall_if_2, c < 7);
         chk1("s2 stall_mem", stall_mem_2, c < 3);
         chk1("s2 d_ready", d_ready_2, c == 3);
         chk1("s2 if_ready", if_ready_2, c == 7);
         if (c == 3) chk32("s2 d_rdata", d_rdata_2, 32'h0100_FEFF);
         if (c == 5) chk32("s2 fetch addr", mem_addr_2, 32'h44);
         if (c == 7) chk32("s2 if_rdata", if_rdata_2, 32'h0044_FFBB);
         tick();
         if (c == 3) d_req = 1'b0;
      end
      if_req = 1'b0;
      repeat (4) tick();
      do_reset();

      // Starvation guard: data held, fetch held
      if_req = 1'b1; if_addr = 32'h80;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      for (int c = 0; c < 24; c++) begin
         #1;
         chk1("s3 d_ready", d_ready_2, (c % 4 == 3) && c != 19);
         chk1("s3 if_ready", if_ready_2, c == 19);
         chk1("s3 stall_if", stall_if_2, c != 19);
         if (c == 17) chk32("s3 fetch addr", mem_addr_2, 32'h80);
         if (c == 23) chk32("s3 d_rdata", d_rdata_2, 32'h0210_FDEF);
         if (c <= 14) begin
            chk1("s3 L1 if_ready", if_ready_1, c == 14);
            chk1("s3 L1 d_ready", d_ready_1, (c % 3 == 2) && c < 12);
         end
         tick();
         if ((c % 4 == 3) && c != 19) d_addr = d_addr + 32'd4;
         if (c == 19) if_addr = 32'h84;
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (3) tick();

      // Store, with inputs disturbed mid-access
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (c == 1 || c == 2) begin
            chk1 ("s4 mem_we", mem_we_2, 1'b1);
            chk32("s4 mem_addr", mem_addr_2, 32'h10);
            chk32("s4 mem_wdata", mem_wdata_2, 32'hDEAD_BEEF);
         end
         if (c == 3) begin
            chk1 ("s4 d_ready", d_ready_2, 1'b1);
            chk32("s4 d_rdata kept", d_rdata_2, 32'h0210_FDEF);
         end
         tick();
         if (c == 0) begin d_addr = 32'h999; d_wdata = 32'h0; end
         if (c == 3) begin d_req = 1'b0; d_we = 1'b0; end
      end
      repeat (3) tick();

      // Reset mid-access, then a normal fetch
      if_req = 1'b1; if_addr = 32'h60;
      for (int c = 0; c < 7; c++) begin
         if (c == 2) reset_n = 1'b0;
         #1;
         if (c == 1 || c == 2) chk1("s5 mem_en pre", mem_en_2, 1'b1);
         if (c == 3) begin
            chk1 ("s5 mem_en", mem_en_2, 1'b0);
            chk1 ("s5 mem_we", mem_we_2, 1'b0);
            chk1 ("s5 if_ready", if_ready_2, 1'b0);
            chk1 ("s5 d_ready", d_ready_2, 1'b0);
            chk32("s5 mem_addr", mem_addr_2, 32'h0);
            chk32("s5 mem_wdata", mem_wdata_2, 32'h0);
            chk32("s5 if_rdata", if_rdata_2, 32'h0);
            chk32("s5 d_rdata", d_rdata_2, 32'h0);
            chk1 ("s5 stall_if", stall_if_2, 1'b1);
         end
         if (c == 4 || c == 5) chk32("s5 mem_addr post", mem_addr_2, 32'h60);
         chk1("s5 if_ready seq", if_ready_2, c == 6);
         if (c == 6) chk32("s5 if_rdata post", if_rdata_2, 32'h0060_FF9F);
         tick();
         if (c == 2) reset_n = 1'b1;
      end
      if_req = 1'b0;
      repeat (3) tick();

      // Load withdrawn after grant still completes
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk1("s6 d_ready", d_ready_2, c == 3);
         if (c == 3) chk32("s6 d_rdata", d_rdata_2, 32'h0300_FCFF);
         tick();
         if (c == 0) d_req = 1'b0;
      end
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Arbitrates requests with data priority and a fetch anti-starvation guard, and holds the memory interface stable for a fixed multi-cycle access latency. Returns read data with a one-cycle ready pulse, and drives per-stage stall signals into the pipeline's hazard/stall logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles, must be ≥1
- STARVE_MAX, 4, consecutive data wins tolerated while fetch waits, ≥1
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset: one clock; reset is synchronous and active-low
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_ready
- if_ready  out  1  one-cycle completion pulse, fetch
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ready
- d_ready  out  1  one-cycle completion pulse, data
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle
- stall_if  out  1  if_req & ~if_ready, combinational
- stall_mem  out  1  d_req & ~d_ready, combinational

## Operation
- FSM states and transitions:
  - IDLE: arbitrate. If no request, stay in IDLE. If any request, go to ACCESS.
  - ACCESS: lasts exactly MEM_LAT cycles, then goes to DONE.
  - DONE: pulse the winning port's ready signal, then go to IDLE.
- Arbitration, sampled only in IDLE:
  - d_req only → data wins.
  - if_req only → fetch wins.
  - Both requesting → data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments on each data grant made while if_req = 1.
  - Clears on any fetch grant.
  - Saturates at STARVE_MAX.
- On grant, latch owner, address, we and wdata. The mem_* outputs are driven from these latches for all MEM_LAT ACCESS cycles, so they stay stable even if inputs change.
- Fetch is always a read: mem_we = 0.
- In the last ACCESS cycle, register mem_rdata into the owner's rdata output.
- Stores leave d_rdata unchanged.
- In DONE, exactly one of if_ready/d_ready is 1. mem_en = 0 in IDLE and in DONE.
- The non-owner's rdata holds its previous value.
- Requests raised or dropped during ACCESS/DONE are not seen until the next IDLE.
- A request withdrawn mid-access is a protocol violation. The access still completes and ready still pulses.
- Reset (reset_n = 0 at a rising edge) takes effect at any state, mid-access included:
  - State → IDLE, starve_cnt → 0.
  - The in-flight access is abandoned, with no ready pulse.
  - All registered outputs → 0: if_rdata, d_rdata, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata.

## Timing
- Request first seen in IDLE at cycle t:
  - ACCESS occupies t+1 … t+MEM_LAT.
  - Ready pulses at t+MEM_LAT+1.
  - The next IDLE is t+MEM_LAT+2.
- Occupancy: MEM_LAT+2 cycles per access, including IDLE. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- A requester that advances on ready presents its next request in the next IDLE cycle; no dead cycle is added.
- The losing requester waits a full access, and its stall stays high throughout.
- Stall signals are combinational from req and registered ready. They must not loop back into req in the same cycle.

## Structure
- Shared package holds:
  - State encoding: ST_IDLE, ST_ACCESS, ST_DONE.
  - Owner encoding: OWN_IF, OWN_D.
  - Default widths for ADDR_W/DATA_W, shared with the pipeline.
- One sub-module, mem_lat_counter:
  - Loads MEM_LAT-1 on grant, decrements in ACCESS.
  - Flags the last cycle.
  - Clears on reset.
- The arbiter FSM, starve counter and output latches live in the top module.

## Test plan
- Fetch only, MEM_LAT = 2: if_req = 1, if_addr = 0x40 at cycle 0, mem_rdata = 0x8C220004.
  - Expect mem_en = 1 with mem_addr = 0x40 at cycles 1–2.
  - Expect if_ready at cycle 3 with if_rdata = 0x8C220004.
  - Expect stall_if = 1 at cycles 0–2.
- Simultaneous: if_req = d_req = 1 at cycle 0 (load, d_addr = 0x100).
  - Expect d_ready at cycle 3 and fetch granted at cycle 4.
  - Expect if_ready at cycle 7 and stall_if high at cycles 0–6.
- Starvation, STARVE_MAX = 4: d_req re-raised every IDLE and if_req held.
  - Expect four data grants, fetch on the fifth grant, then starve_cnt = 0.
- Store: d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF.
  - Expect mem_we = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF at cycles 1–2.
  - Expect d_ready at cycle 3 and d_rdata unchanged.
- Reset mid-access: reset_n = 0 sampled at cycle 2.
  - Expect IDLE, mem_en = 0 and all outputs 0 at cycle 3, with no ready pulse.
  - A subsequent fetch completes with normal timing.
- MEM_LAT = 1 build: a single-cycle ACCESS gives ready at t+2. The starvation case repeats correctly.
